player_table: RTL and testbench

- Multi-seat successor to the single-seat player block: holds stack, hole cards, fold/all-in flags and street contribution for NUM_PLAYERS seats, plus the shared pot.
- Sits between the game-control FSM and the display/eval logic.
- Commands arrive over a valid/ready port.
- Pot awards to one or more winners are split over several cycles by an internal distribution FSM.

---
 rtl/player_table.sv | 252 +++++++++++++++++++++++++
 tb/tb_player_table.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_table.sv
// Multi-seat poker table state: stacks, hole cards, fold/all-in flags, street bets and the shared pot.
// Single-cycle ops finish on the accepting edge (done/error next cycle); AWARD takes 1 + max(1,q) + NUM_PLAYERS cycles.
// cmd_ready is high only in IDLE; commands are held off for the whole award. Optional PLAYER_TABLE_CONSERVE_EN adds a chip-conservation monitor.
module player_table #(
   parameter int                 NUM_PLAYERS   = 4,
   parameter int                 STACK_W       = 16,
   parameter logic [STACK_W-1:0] DEFAULT_STACK = STACK_W'(500),
   parameter int                 SEAT_W        = $clog2(NUM_PLAYERS)
) (
   input  logic                                 clk,
   input  logic                                 player_reset,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [2:0]                           cmd_op,
   input  logic [SEAT_W-1:0]                    cmd_seat,
   input  logic [STACK_W-1:0]                   cmd_amount,
   input  logic [1:0][5:0]                      cmd_cards,
   input  logic [NUM_PLAYERS-1:0]               cmd_winners,
   output logic [NUM_PLAYERS-1:0][STACK_W-1:0]  stacks,
   output logic [NUM_PLAYERS-1:0][STACK_W-1:0]  street_bet,
   output logic [NUM_PLAYERS-1:0][1:0][5:0]     cards,
   output logic [NUM_PLAYERS-1:0]               folded,
   output logic [NUM_PLAYERS-1:0]               all_in,
   output logic [STACK_W-1:0]                   pot,
   output logic [STACK_W-1:0]                   max_street_bet,
   output logic                                 done,
   output logic                                 error
`ifdef PLAYER_TABLE_CONSERVE_EN
   ,
   output logic [STACK_W+SEAT_W:0]              total_chips,
   output logic                                 conserve_err
`endif
);

   localparam int IDX_W = $clog2(NUM_PLAYERS);
   localparam int SW1   = SEAT_W + 1;

   localparam logic [2:0] OP_SET_CARDS  = 3'd0;
   localparam logic [2:0] OP_BET        = 3'd1;
   localparam logic [2:0] OP_FOLD       = 3'd2;
   localparam logic [2:0] OP_AWARD      = 3'd3;
   localparam logic [2:0] OP_NEW_STREET = 3'd4;
   localparam logic [2:0] OP_NEW_HAND   = 3'd5;

   // Card encoding is {suit[1:0], rank[3:0]}, rank 2..14, suit 3 = spades.
   localparam logic [5:0] ACE_SPADES = 6'h3E;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DIVIDE, S_PAY} state_t;

   state_t                  state;
   logic [NUM_PLAYERS-1:0]  winners_q;
   logic [NUM_PLAYERS-1:0]  elig_q;
   logic [SW1-1:0]          n_q;
   logic [STACK_W-1:0]      rem_q;
   logic [STACK_W-1:0]      share_q;
   logic [IDX_W-1:0]        pay_idx;
   logic                    paid_q;

   logic [IDX_W-1:0]        seat_idx;
   logic                    seat_ok;
   logic [STACK_W-1:0]      cur_stack;
   logic [STACK_W-1:0]      bet_actual;
   logic [STACK_W:0]        pot_sum;
   logic                    reject;
   logic [NUM_PLAYERS-1:0]  elig_win;
   logic [SW1-1:0]          win_cnt;
   logic [STACK_W-1:0]      n_ext;
   logic [STACK_W-1:0]      div_next;
   logic [STACK_W-1:0]      pay_amt;
   logic [STACK_W:0]        pay_sum;

   assign cmd_ready = (state == S_IDLE);

   // Decode the offered command: target seat, clipped bet and reject conditions.
   always_comb begin
      seat_idx   = cmd_seat[IDX_W-1:0];
      seat_ok    = ({1'b0, cmd_seat} < SW1'(NUM_PLAYERS));
      cur_stack  = stacks[seat_idx];
      bet_actual = (cmd_amount < cur_stack) ? cmd_amount : cur_stack;
      pot_sum    = {1'b0, pot} + {1'b0, bet_actual};
      reject     = 1'b0;
      case (cmd_op)
         OP_SET_CARDS:  reject = !seat_ok;
         OP_BET:        reject = !seat_ok || folded[seat_idx] || all_in[seat_idx];
         OP_FOLD:       reject = !seat_ok || folded[seat_idx];
         OP_AWARD:      reject = ((cmd_winners & ~folded) == '0);
         OP_NEW_STREET: reject = 1'b0;
         OP_NEW_HAND:   reject = (pot != '0);
         default:       reject = 1'b1;
      endcase
   end

   // Award datapath: eligible-winner count, next division remainder and the current seat's payout.
   always_comb begin
      elig_win = winners_q & ~folded;
      win_cnt  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         win_cnt = win_cnt + SW1'(elig_win[i]);
      end
      n_ext    = STACK_W'(n_q);
      div_next = rem_q - n_ext;
      pay_amt  = share_q + (paid_q ? '0 : rem_q);
      pay_sum  = {1'b0, stacks[pay_idx]} + {1'b0, pay_amt};
   end

   // Largest chip count any seat has put in on this street.
   always_comb begin
      max_street_bet = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (street_bet[i] > max_street_bet) max_street_bet = street_bet[i];
      end
   end

   // Command execution and the COUNT/DIVIDE/PAY award sequencer.
   always_ff @(posedge clk) begin
      if (player_reset) begin
         state      <= S_IDLE;
         pot        <= '0;
         street_bet <= '0;
         folded     <= '0;
         all_in     <= '0;
         winners_q  <= '0;
         elig_q     <= '0;
         n_q        <= '0;
         rem_q      <= '0;
         share_q    <= '0;
         pay_idx    <= '0;
         paid_q     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            stacks[i] <= DEFAULT_STACK;
            cards[i]  <= {ACE_SPADES, ACE_SPADES};
         end
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (reject) begin
                     error <= 1'b1;
                  end else begin
                     case (cmd_op)
                        OP_SET_CARDS: begin
                           cards[seat_idx] <= cmd_cards;
                           done            <= 1'b1;
                        end
                        OP_BET: begin
                           stacks[seat_idx]     <= cur_stack - bet_actual;
                           street_bet[seat_idx] <= street_bet[seat_idx] + bet_actual;
                           pot                  <= pot_sum[STACK_W] ? '1 : pot_sum[STACK_W-1:0];
                           if (cur_stack == bet_actual) all_in[seat_idx] <= 1'b1;
                           done                 <= 1'b1;
                        end
                        OP_FOLD: begin
                           folded[seat_idx] <= 1'b1;
                           done             <= 1'b1;
                        end
                        OP_AWARD: begin
                           winners_q <= cmd_winners;
                           state     <= S_COUNT;
                        end
                        OP_NEW_STREET: begin
                           street_bet <= '0;
                           done       <= 1'b1;
                        end
                        OP_NEW_HAND: begin
                           street_bet <= '0;
                           folded     <= '0;
                           all_in     <= '0;
                           done       <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_COUNT: begin
               n_q     <= win_cnt;
               elig_q  <= elig_win;
               rem_q   <= pot;
               share_q <= '0;
               pay_idx <= '0;
               paid_q  <= 1'b0;
               state   <= S_DIVIDE;
            end
            S_DIVIDE: begin
               // Repeated subtraction; a single winner skips straight to the full pot.
               if (n_q == SW1'(1)) begin
                  share_q <= rem_q;
                  rem_q   <= '0;
                  state   <= S_PAY;
               end else if (rem_q >= n_ext) begin
                  rem_q   <= div_next;
                  share_q <= share_q + 1'b1;
                  if (div_next < n_ext) state <= S_PAY;
               end else begin
                  state <= S_PAY;
               end
            end
            S_PAY: begin
               if (elig_q[pay_idx]) begin
                  stacks[pay_idx] <= pay_sum[STACK_W] ? '1 : pay_sum[STACK_W-1:0];
                  paid_q          <= 1'b1;
               end
               if (pay_idx == IDX_W'(NUM_PLAYERS - 1)) begin
                  pot   <= '0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  pay_idx <= pay_idx + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PLAYER_TABLE_CONSERVE_EN
   localparam int TW = STACK_W + SEAT_W + 1;
   localparam logic [TW-1:0] TOTAL_RST = TW'(NUM_PLAYERS) * TW'(DEFAULT_STACK);

   logic [TW-1:0] chip_sum;
   logic          prev_idle;
   logic          sat_q;

   // Every chip on the table: all stacks plus the pot.
   always_comb begin
      chip_sum = TW'(pot);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         chip_sum = chip_sum + TW'(stacks[i]);
      end
   end

   // Flag any change of the chip total across two idle cycles unless a pot saturation just clipped it.
   always_ff @(posedge clk) begin
      if (player_reset) begin
         total_chips  <= TOTAL_RST;
         conserve_err <= 1'b0;
         prev_idle    <= 1'b1;
         sat_q        <= 1'b0;
      end else begin
         total_chips <= chip_sum;
         prev_idle   <= (state == S_IDLE);
         sat_q       <= (state == S_IDLE) && cmd_valid && !reject && (cmd_op == OP_BET) && pot_sum[STACK_W];
         if ((state == S_IDLE) && prev_idle && !sat_q && (total_chips != chip_sum)) conserve_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_player_table.sv
// Scoreboard bench for player_table: stimulus pushes expected table snapshots, a monitor compares on done/error.
// Directed scenarios cover bets, clipping, rejects, odd-chip award split, single-winner award and reset mid-award.
// Award busy time is measured against the hand-computed latency.
module tb_player_table;

   logic                  clk;
   logic                  player_reset;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [2:0]            cmd_op;
   logic [2:0]            cmd_seat;
   logic [15:0]           cmd_amount;
   logic [1:0][5:0]       cmd_cards;
   logic [3:0]            cmd_winners;
   logic [3:0][15:0]      stacks;
   logic [3:0][15:0]      street_bet;
   logic [3:0][1:0][5:0]  cards;
   logic [3:0]            folded;
   logic [3:0]            all_in;
   logic [15:0]           pot;
   logic [15:0]           max_street_bet;
   logic                  done;
   logic                  error;
`ifdef PLAYER_TABLE_CONSERVE_EN
   logic [19:0]           total_chips;
   logic                  conserve_err;
`endif

   player_table #(
      .NUM_PLAYERS(4), .STACK_W(16), .DEFAULT_STACK(16'd500), .SEAT_W(3)
   ) dut (
      .clk(clk), .player_reset(player_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_seat(cmd_seat),
      .cmd_amount(cmd_amount), .cmd_cards(cmd_cards), .cmd_winners(cmd_winners),
      .stacks(stacks), .street_bet(street_bet), .cards(cards), .folded(folded), .all_in(all_in),
      .pot(pot), .max_street_bet(max_street_bet), .done(done), .error(error)
`ifdef PLAYER_TABLE_CONSERVE_EN
      , .total_chips(total_chips), .conserve_err(conserve_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic                 err;
      logic [3:0][15:0]     stk;
      logic [3:0][15:0]     sb;
      logic [15:0]          pot;
      logic [3:0]           fld;
      logic [3:0]           ain;
      logic [3:0][1:0][5:0] crd;
   } exp_t;

   exp_t                 exp_q[$];
   exp_t                 mon_e;
   int                   total = 0;
   int                   bad   = 0;

   logic [3:0][15:0]     e_stk;
   logic [3:0][15:0]     e_sb;
   logic [15:0]          e_pot;
   logic [3:0]           e_fld;
   logic [3:0]           e_ain;
   logic [3:0][1:0][5:0] e_crd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic reset_exp();
      e_stk = {4{16'd500}};
      e_sb  = '0;
      e_pot = '0;
      e_fld = '0;
      e_ain = '0;
      e_crd = {8{6'h3E}};
   endtask

   task automatic push_exp(input logic err);
      exp_t e;
      e.err = err; e.stk = e_stk; e.sb = e_sb; e.pot = e_pot;
      e.fld = e_fld; e.ain = e_ain; e.crd = e_crd;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] seat, input logic [15:0] amt,
                       input logic [3:0] win, input bit want_resp, input bit want_err);
      int i;
      i = 0;
      @(negedge clk);
      while (!cmd_ready && i < 500) begin
         @(negedge clk);
         i++;
      end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, i);
      end
      cmd_op = op; cmd_seat = seat; cmd_amount = amt; cmd_winners = win; cmd_valid = 1'b1;
      if (want_resp) push_exp(want_err);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic award_wait(input int want_cycles, input string name);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
         cnt++;
      end
      check(name, 64'(cnt), 64'(want_cycles));
   endtask

   task automatic do_reset();
      @(negedge clk);
      player_reset = 1'b1;
      @(posedge clk);
      #1 player_reset = 1'b0;
      reset_exp();
   endtask

   // Monitor: every done/error pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done || error) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: done=%b error=%b, want no response", done, error);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_error", 64'(error), 64'(mon_e.err));
            check("resp_done", 64'(done), 64'(!mon_e.err));
            check("resp_stacks", stacks, mon_e.stk);
            check("resp_street", street_bet, mon_e.sb);
            check("resp_pot", 64'(pot), 64'(mon_e.pot));
            check("resp_flags", {folded, all_in}, {mon_e.fld, mon_e.ain});
            check("resp_cards", 64'(cards), 64'(mon_e.crd));
         end
      end
   end

   initial begin
      player_reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_seat = '0;
      cmd_amount = '0; cmd_cards = '0; cmd_winners = '0;
      reset_exp();
      repeat (2) @(posedge clk);
      #1 player_reset = 1'b0;

      @(negedge clk);
      check("rst_stacks", stacks, 64'h01F4_01F4_01F4_01F4);
      check("rst_pot_street", {pot, street_bet}, 80'h0);
      check("rst_ready_done_err", {cmd_ready, done, error}, 3'b100);
      check("rst_cards", 64'(cards), 64'({8{6'h3E}}));
      check("rst_flags", {folded, all_in}, 8'h00);
`ifdef PLAYER_TABLE_CONSERVE_EN
      check("rst_total_chips", 64'(total_chips), 64'd2000);
`endif

      // SET_CARDS seat 2, then BET seat 1 of 120
      cmd_cards = {6'h1C, 6'h2A};
      e_crd[2][0] = 6'h2A; e_crd[2][1] = 6'h1C;
      send(3'd0, 3'd2, 16'd0, 4'b0, 1, 0);
      e_stk[1] = 16'd380; e_sb[1] = 16'd120; e_pot = 16'd120;
      send(3'd1, 3'd1, 16'd120, 4'b0, 1, 0);
      @(negedge clk);
      check("max_street_bet", 64'(max_street_bet), 64'd120);

      // Oversized BET clipped to the stack, then a check to the all-in seat is rejected
      do_reset();
      e_stk[2] = 16'd0; e_sb[2] = 16'd500; e_pot = 16'd500; e_ain[2] = 1'b1;
      send(3'd1, 3'd2, 16'd700, 4'b0, 1, 0);
      send(3'd1, 3'd2, 16'd0, 4'b0, 1, 1);

      // Pot 301 split between seats 1 and 3; seat 1 takes the odd chip
      do_reset();
      e_stk[0] = 16'd199; e_sb[0] = 16'd301; e_pot = 16'd301;
      send(3'd1, 3'd0, 16'd301, 4'b0, 1, 0);
      e_stk[1] = 16'd651; e_stk[3] = 16'd650; e_pot = 16'd0;
      send(3'd3, 3'd0, 16'd0, 4'b1010, 1, 0);
      award_wait(155, "award301_busy_cycles");

      e_sb = '0;
      send(3'd4, 3'd0, 16'd0, 4'b0, 1, 0);
      e_fld[0] = 1'b1;
      send(3'd2, 3'd0, 16'd0, 4'b0, 1, 0);
      e_stk[3] = 16'd600; e_sb[3] = 16'd50; e_pot = 16'd50;
      send(3'd1, 3'd3, 16'd50, 4'b0, 1, 0);
      send(3'd3, 3'd0, 16'd0, 4'b0001, 1, 1);   // only a folded winner
      send(3'd3, 3'd0, 16'd0, 4'b0000, 1, 1);   // empty mask
      send(3'd5, 3'd0, 16'd0, 4'b0, 1, 1);      // NEW_HAND with pot 50
      send(3'd1, 3'd0, 16'd10, 4'b0, 1, 1);     // BET to folded seat
      send(3'd2, 3'd0, 16'd0, 4'b0, 1, 1);      // FOLD to folded seat

      // Single eligible winner: whole pot in one divide cycle
      e_stk[1] = 16'd701; e_pot = 16'd0;
      send(3'd3, 3'd0, 16'd0, 4'b0011, 1, 0);
      award_wait(6, "award_single_busy_cycles");

      e_sb = '0; e_fld = '0; e_ain = '0;
      send(3'd5, 3'd0, 16'd0, 4'b0, 1, 0);
      send(3'd6, 3'd0, 16'd0, 4'b0, 1, 1);
      send(3'd7, 3'd0, 16'd0, 4'b0, 1, 1);
      send(3'd0, 3'd5, 16'd0, 4'b0, 1, 1);      // seat 5 out of range
      send(3'd1, 3'd4, 16'd10, 4'b0, 1, 1);     // seat 4 out of range
      repeat (3) @(negedge clk);
`ifdef PLAYER_TABLE_CONSERVE_EN
      check("total_chips_after_play", 64'(total_chips), 64'd2000);
      check("conserve_err", 64'(conserve_err), 64'd0);
`endif

      // Reset while the award is paying out
      do_reset();
      e_stk[0] = 16'd300; e_sb[0] = 16'd200; e_pot = 16'd200;
      send(3'd1, 3'd0, 16'd200, 4'b0, 1, 0);
      send(3'd3, 3'd0, 16'd0, 4'b0110, 0, 0);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (stacks[1] != 16'd500) break;
      end
      check("pay_seat1_share", 64'(stacks[1]), 64'd600);
      check("pay_busy", 64'(cmd_ready), 64'd0);
      player_reset = 1'b1;
      @(posedge clk);
      #1 player_reset = 1'b0;
      reset_exp();
      @(negedge clk);
      check("midaward_stacks", stacks, 64'h01F4_01F4_01F4_01F4);
      check("midaward_pot_street", {pot, street_bet}, 80'h0);
      check("midaward_ready", 64'(cmd_ready), 64'd1);

      e_stk[3] = 16'd490; e_sb[3] = 16'd10; e_pot = 16'd10;
      send(3'd1, 3'd3, 16'd10, 4'b0, 1, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
